arm_regfile_gen: RTL and testbench
==================================

Name: arm_regfile_gen

Overview:
- Parametrised successor to the fixed 16 x 32 datapath register file.
- Width and register count are generic.
- Adds a self-incrementing PC in R15, a dedicated link-register write into R14 for BL, and optional write-to-read forwarding.
- Instantiated as `registers` inside the datapath, replacing the hand-wired R0..R15 array.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 16, number of architectural registers; must be >= 16.
- ADDR_W, 4, register address width; must be >= clog2(NUM_REGS).
- PC_INC, 4, amount added to R15 on each enabled increment.
- PC_RESET, 0, value loaded into R15 on reset.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Clr  in  1  reset; synchronous, active-high.
- wa_en  in  1  general write enable.
- wa_addr  in  ADDR_W  general write address.
- wa_data  in  DATA_W  general write data.
- lr_wr  in  1  link write: R14 <= current PC.
- pc_en  in  1  PC increment enable.
- ra_addr  in  ADDR_W  read port A address.
- rb_addr  in  ADDR_W  read port B address.
- ra_data  out  DATA_W  read port A data; combinational.
- rb_data  out  DATA_W  read port B data; combinational.
- pc_out  out  DATA_W  current R15 value (pc_q).

Behaviour:
- Reset:
  - Clr=1 at a rising edge sets every register to 0, except R15, which is set to PC_RESET.
  - Clr overrides all writes and increments in that cycle.
  - Reset takes effect mid-sequence with no drain.
- Reads:
  - Combinational from storage.
  - Addresses >= NUM_REGS read as 0.
  - R15 reads return pc_q exactly; no +8 pipeline offset.
- General write:
  - wa_en=1 and wa_addr < NUM_REGS: register[wa_addr] <= wa_data at the edge.
  - Out-of-range wa_addr: write ignored.
- Link write:
  - lr_wr=1: R14 <= pc_q, the value before any increment this edge.
- R15 update, highest priority first:
  - Clr.
  - wa_en with wa_addr=15 (branch target).
  - pc_en: pc_q + PC_INC, modulo 2^DATA_W; wraps silently.
  - Otherwise hold.
- R14 update, highest priority first:
  - Clr.
  - wa_en with wa_addr=14.
  - lr_wr.
  - Otherwise hold.
- Simultaneous events:
  - wa_en to R15 together with lr_wr: R14 gets the old PC and R15 gets wa_data in the same edge (BL resolution).
  - All other registers have a single writer, so no conflict arises.
- Latency: a write is visible on the read ports one cycle after the edge (no-forward build).
- pc_out: equals pc_q; 0-latency view of R15.

Optional Feature:
- Macro: ARM_REGFILE_BYPASS_EN.
- Defined:
  - A read port whose address matches a pending write this cycle returns the incoming value instead of storage.
  - wa_en hit returns wa_data.
  - R14 hit with lr_wr, and no wa_en to 14, returns pc_q.
  - The R15 increment is NOT forwarded; R15 reads always return pc_q unless wa_en targets 15.
  - Forwarding is suppressed while Clr=1.
- Undefined: reads always return storage, i.e. the old value during a same-cycle write.

Decomposition:
- Package arm_dp_pkg holds:
  - Constants REG_SP=13, REG_LR=14, REG_PC=15.
  - DEF_DATA_W=32.
  - typedef reg_addr_t, logic[3:0].
- Sub-module reg_cell:
  - Ports: Clk, Clr, LE, D, Q; parameters DATA_W and RST_VAL.
  - NUM_REGS instances via generate.
  - The R14 and R15 instances take muxed D/LE from the top-level priority logic.

Test Plan:
- Clr=1 for 2 cycles, then 0 -> every ra_data sweep reads 0 and pc_out=PC_RESET (0).
- wa_en=1, wa_addr=1, wa_data=32'h0000_1001; next cycle ra_addr=1 -> ra_data=32'h0000_1001. Same-cycle read returns 0 without BYPASS_EN and 32'h0000_1001 with it.
- pc_en=1 for 3 cycles from pc=0 -> pc_out 4, 8, 12. Then set PC to 32'hFFFF_FFFC via wa_addr=15; pc_en=1 one cycle -> pc_out=0 (wrap).
- pc=32'h100; same edge wa_en=1, wa_addr=15, wa_data=32'h200, lr_wr=1, pc_en=1 -> R14=32'h100, R15=32'h200 (increment dropped).
- Same edge wa_en=1, wa_addr=14, wa_data=32'hABCD, lr_wr=1 -> R14=32'hABCD.
- Registers loaded with nonzero data; Clr=1 for one edge mid-sequence while wa_en=1 to R3 -> all regs 0, R15=PC_RESET, the R3 write lost. ra_addr=16 (with ADDR_W=5) -> ra_data=0.

Source files
------------

// File: rtl/arm_dp_pkg.sv
// Shared datapath constants for the ARM-style register file.
package arm_dp_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int REG_SP     = 13;
  localparam int REG_LR     = 14;
  localparam int REG_PC     = 15;

  typedef logic [3:0] reg_addr_t;

endpackage

// File: rtl/arm_regfile_gen_if.sv
// Register-file access bundle: one write port, link/PC controls, two read ports and the PC view.
interface arm_regfile_gen_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              wa_en;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data;
  logic              lr_wr;
  logic              pc_en;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic [DATA_W-1:0] pc_out;

  modport master (
    output wa_en, wa_addr, wa_data, lr_wr, pc_en, ra_addr, rb_addr,
    input  ra_data, rb_data, pc_out
  );

  modport slave (
    input  wa_en, wa_addr, wa_data, lr_wr, pc_en, ra_addr, rb_addr,
    output ra_data, rb_data, pc_out
  );
endinterface

// File: rtl/arm_regfile_gen_reg_cell.sv
// Single architectural register: synchronous clear to RST_VAL, load on LE.
module reg_cell #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              LE,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] Q
);
  logic [DATA_W-1:0] q_q;

  always_ff @(posedge Clk) begin
    if (Clr)     q_q <= RST_VAL;
    else if (LE) q_q <= D;
  end

  assign Q = q_q;
endmodule

// File: rtl/arm_regfile_gen.sv
// Generic register file with self-incrementing PC (R15) and BL link write (R14).
// Define ARM_REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module arm_regfile_gen
  import arm_dp_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 16,
  parameter int                ADDR_W   = 4,
  parameter int                PC_INC   = 4,
  parameter logic [DATA_W-1:0] PC_RESET = '0
) (
  input  logic             Clk,
  input  logic             Clr,
  arm_regfile_gen_if.slave bus
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;
  logic [NUM_REGS-1:0]             le;
  logic [NUM_REGS-1:0]             wa_hit;
  logic [DATA_W-1:0]               pc_q;
  logic [DATA_W-1:0]               ra_c, rb_c;

  assign pc_q = regs_q[REG_PC];

  // One-hot decode of the write port; out-of-range addresses hit nothing.
  always_comb begin
    wa_hit = '0;
    for (int k = 0; k < NUM_REGS; k++)
      wa_hit[k] = bus.wa_en && (bus.wa_addr == ADDR_W'(k));
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == REG_PC) begin : g_pc
      // A branch target beats the increment.
      assign le[i]     = wa_hit[i] | bus.pc_en;
      assign regs_d[i] = wa_hit[i] ? bus.wa_data : pc_q + DATA_W'(PC_INC);
    end else if (i == REG_LR) begin : g_lr
      // Link captures the pre-increment PC; an explicit write wins.
      assign le[i]     = wa_hit[i] | bus.lr_wr;
      assign regs_d[i] = wa_hit[i] ? bus.wa_data : pc_q;
    end else begin : g_gp
      assign le[i]     = wa_hit[i];
      assign regs_d[i] = bus.wa_data;
    end

    reg_cell #(
      .DATA_W  (DATA_W),
      .RST_VAL ((i == REG_PC) ? PC_RESET : '0)
    ) u_cell (
      .Clk (Clk),
      .Clr (Clr),
      .LE  (le[i]),
      .D   (regs_d[i]),
      .Q   (regs_q[i])
    );
  end

  function automatic logic [DATA_W-1:0] rd_mux(
    input logic [ADDR_W-1:0]                 a,
    input logic [NUM_REGS-1:0][DATA_W-1:0] st
  );
    rd_mux = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (a == ADDR_W'(k)) rd_mux = st[k];
  endfunction

`ifdef ARM_REGFILE_BYPASS_EN
  logic wr_fwd, lr_fwd;
  assign wr_fwd = |wa_hit;
  assign lr_fwd = bus.lr_wr && !wa_hit[REG_LR];
`endif

  always_comb begin
    ra_c = rd_mux(bus.ra_addr, regs_q);
    rb_c = rd_mux(bus.rb_addr, regs_q);
`ifdef ARM_REGFILE_BYPASS_EN
    // The PC increment is deliberately not forwarded; only explicit writes are.
    if (!Clr) begin
      if (lr_fwd && bus.ra_addr == ADDR_W'(REG_LR))   ra_c = pc_q;
      if (lr_fwd && bus.rb_addr == ADDR_W'(REG_LR))   rb_c = pc_q;
      if (wr_fwd && bus.ra_addr == bus.wa_addr)       ra_c = bus.wa_data;
      if (wr_fwd && bus.rb_addr == bus.wa_addr)       rb_c = bus.wa_data;
    end
`endif
  end

  assign bus.ra_data = ra_c;
  assign bus.rb_data = rb_c;
  assign bus.pc_out  = pc_q;
endmodule

// File: tb/tb_arm_regfile_gen.sv
// Self-checking bench for arm_regfile_gen against an array-based reference model.
module tb_arm_regfile_gen;
  localparam int          DW  = 32;
  localparam int          NR  = 16;
  localparam int          AW  = 5;
  localparam int          PCI = 4;
  localparam logic [31:0] PCR = 32'h0;

  logic Clk = 1'b0;
  logic Clr;
  always #5 Clk = ~Clk;

  arm_regfile_gen_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

  arm_regfile_gen #(
    .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .PC_INC(PCI), .PC_RESET(PCR)
  ) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus.slave)
  );

  logic [31:0] m [NR];
  int n_chk  = 0;
  int n_fail = 0;

  // Architectural read as seen this cycle, including same-cycle forwarding when built in.
  function automatic logic [31:0] exp_rd(input logic [AW-1:0] a);
    int ai = int'(a);
    if (ai >= NR) return 32'h0;
`ifdef ARM_REGFILE_BYPASS_EN
    if (!Clr) begin
      if (bus.wa_en && int'(bus.wa_addr) == ai) return bus.wa_data;
      if (bus.lr_wr && ai == 14) return m[15];
    end
`endif
    return m[ai];
  endfunction

  task automatic idle();
    bus.wa_en = 0; bus.wa_addr = '0; bus.wa_data = '0;
    bus.lr_wr = 0; bus.pc_en = 0;
  endtask

  // Advance one edge, applying the architectural rules to the model.
  task automatic edge_();
    logic [31:0] old_pc;
    @(posedge Clk);
    old_pc = m[15];
    if (Clr) begin
      foreach (m[k]) m[k] = 32'h0;
      m[15] = PCR;
    end else begin
      if (bus.lr_wr) m[14] = old_pc;
      if (bus.pc_en) m[15] = old_pc + PCI;
      if (bus.wa_en && int'(bus.wa_addr) < NR) m[int'(bus.wa_addr)] = bus.wa_data;
    end
    #1;
  endtask

  task automatic test_reset();
    idle(); Clr = 1;
    edge_(); edge_();
    Clr = 0;
    for (int a = 0; a < 32; a++) begin
      bus.ra_addr = AW'(a); bus.rb_addr = AW'(31 - a); #1;
      n_chk++;
      if (bus.ra_data !== ((a == 15) ? PCR : 32'h0)) begin
        n_fail++; $display("FAIL reset_ra[%0d] got %h want %h", a, bus.ra_data, (a == 15) ? PCR : 32'h0);
      end
    end
    n_chk++;
    if (bus.pc_out !== PCR) begin n_fail++; $display("FAIL reset_pc got %h want %h", bus.pc_out, PCR); end
  endtask

  task automatic test_write_read();
    logic [31:0] same;
`ifdef ARM_REGFILE_BYPASS_EN
    same = 32'h0000_1001;
`else
    same = 32'h0;
`endif
    idle();
    bus.wa_en = 1; bus.wa_addr = 5'd1; bus.wa_data = 32'h0000_1001; bus.ra_addr = 5'd1; #1;
    n_chk++;
    if (bus.ra_data !== same) begin n_fail++; $display("FAIL wr_same_cycle got %h want %h", bus.ra_data, same); end
    edge_(); idle(); bus.rb_addr = 5'd1; #1;
    n_chk++;
    if (bus.ra_data !== 32'h0000_1001) begin n_fail++; $display("FAIL wr_next_ra got %h want 00001001", bus.ra_data); end
    n_chk++;
    if (bus.rb_data !== 32'h0000_1001) begin n_fail++; $display("FAIL wr_next_rb got %h want 00001001", bus.rb_data); end
  endtask

  task automatic test_pc_inc();
    idle(); bus.pc_en = 1;
    for (int k = 1; k <= 3; k++) begin
      edge_();
      n_chk++;
      if (bus.pc_out !== 32'(4 * k)) begin n_fail++; $display("FAIL pc_inc%0d got %h want %h", k, bus.pc_out, 32'(4 * k)); end
    end
    idle(); bus.wa_en = 1; bus.wa_addr = 5'd15; bus.wa_data = 32'hFFFF_FFFC;
    edge_();
    n_chk++;
    if (bus.pc_out !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL pc_load got %h want fffffffc", bus.pc_out); end
    idle(); bus.pc_en = 1;
    edge_(); idle();
    n_chk++;
    if (bus.pc_out !== 32'h0) begin n_fail++; $display("FAIL pc_wrap got %h want 00000000", bus.pc_out); end
  endtask

  task automatic test_bl();
    idle(); bus.wa_en = 1; bus.wa_addr = 5'd15; bus.wa_data = 32'h100;
    edge_();
    bus.wa_data = 32'h200; bus.lr_wr = 1; bus.pc_en = 1;
    edge_(); idle();
    bus.ra_addr = 5'd14; bus.rb_addr = 5'd15; #1;
    n_chk++;
    if (bus.ra_data !== 32'h100) begin n_fail++; $display("FAIL bl_lr got %h want 00000100", bus.ra_data); end
    n_chk++;
    if (bus.rb_data !== 32'h200) begin n_fail++; $display("FAIL bl_pc got %h want 00000200", bus.rb_data); end
    n_chk++;
    if (bus.pc_out !== 32'h200) begin n_fail++; $display("FAIL bl_pcout got %h want 00000200", bus.pc_out); end
  endtask

  task automatic test_lr_conflict();
    idle(); bus.wa_en = 1; bus.wa_addr = 5'd14; bus.wa_data = 32'hABCD; bus.lr_wr = 1;
    bus.ra_addr = 5'd14; #1;
    n_chk++;
    if (bus.ra_data !== exp_rd(5'd14)) begin n_fail++; $display("FAIL lr_conf_same got %h want %h", bus.ra_data, exp_rd(5'd14)); end
    edge_(); idle(); #1;
    n_chk++;
    if (bus.ra_data !== 32'hABCD) begin n_fail++; $display("FAIL lr_conf got %h want 0000abcd", bus.ra_data); end
  endtask

  task automatic test_clr_mid();
    idle();
    for (int r = 0; r < 15; r++) begin
      bus.wa_en = 1; bus.wa_addr = AW'(r); bus.wa_data = 32'h1000 + r; edge_();
    end
    idle(); bus.ra_addr = 5'd3; bus.rb_addr = 5'd16; #1;
    n_chk++;
    if (bus.ra_data !== 32'h1003) begin n_fail++; $display("FAIL load_r3 got %h want 00001003", bus.ra_data); end
    n_chk++;
    if (bus.rb_data !== 32'h0) begin n_fail++; $display("FAIL oob_rd got %h want 00000000", bus.rb_data); end
    // Forwarding is suppressed under Clr, so R3 still shows storage.
    Clr = 1; bus.wa_en = 1; bus.wa_addr = 5'd3; bus.wa_data = 32'hDEAD; #1;
    n_chk++;
    if (bus.ra_data !== 32'h1003) begin n_fail++; $display("FAIL clr_nofwd got %h want 00001003", bus.ra_data); end
    edge_(); Clr = 0; idle();
    for (int a = 0; a < NR; a++) begin
      bus.ra_addr = AW'(a); #1;
      n_chk++;
      if (bus.ra_data !== ((a == 15) ? PCR : 32'h0)) begin
        n_fail++; $display("FAIL clr_mid[%0d] got %h want %h", a, bus.ra_data, (a == 15) ? PCR : 32'h0);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      Clr         = ($urandom_range(0, 29) == 0);
      bus.wa_en   = $urandom_range(0, 1);
      bus.wa_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(14, 15)) : AW'($urandom_range(0, 31));
      bus.wa_data = $urandom;
      bus.lr_wr   = ($urandom_range(0, 3) == 0);
      bus.pc_en   = $urandom_range(0, 1);
      bus.ra_addr = ($urandom_range(0, 1) == 0) ? bus.wa_addr : AW'($urandom_range(0, 31));
      bus.rb_addr = ($urandom_range(0, 2) == 0) ? AW'(14) : AW'($urandom_range(0, 31));
      #1;
      n_chk++;
      if (bus.ra_data !== exp_rd(bus.ra_addr)) begin
        n_fail++; $display("FAIL rand_ra c=%0d a=%0d got %h want %h", c, bus.ra_addr, bus.ra_data, exp_rd(bus.ra_addr));
      end
      n_chk++;
      if (bus.rb_data !== exp_rd(bus.rb_addr)) begin
        n_fail++; $display("FAIL rand_rb c=%0d a=%0d got %h want %h", c, bus.rb_addr, bus.rb_data, exp_rd(bus.rb_addr));
      end
      n_chk++;
      if (bus.pc_out !== m[15]) begin n_fail++; $display("FAIL rand_pc c=%0d got %h want %h", c, bus.pc_out, m[15]); end
      edge_();
    end
    Clr = 0; idle();
  endtask

  initial begin
    Clr = 1; idle(); bus.ra_addr = '0; bus.rb_addr = '0;
    test_reset();
    test_write_read();
    test_pc_inc();
    test_bl();
    test_lr_conflict();
    test_clr_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
